// File: rtl/cache_mem_burst_bridge_if.sv
// Bundles the cache-side block request port and the word-wide memory bus of
// the burst bridge. The master modport is the bridge; the slave modport is the
// environment (cache controller plus memory).
interface cache_mem_burst_bridge_if #(
  parameter int unsigned ADDRSIZE  = 32,
  parameter int unsigned BLOCKSIZE = 128,
  parameter int unsigned WORDSIZE  = 32
);

  // cache-side block request
  logic                 mem_req_vld;
  logic                 mem_req_wen;
  logic [ADDRSIZE-1:0]  mem_addr;
  logic [BLOCKSIZE-1:0] mem_wr_data;
  logic [BLOCKSIZE-1:0] mem_rd_data;
  logic                 mem_req_done;

  // word-wide memory bus
  logic                 bus_cmd_vld;
  logic                 bus_cmd_rdy;
  logic                 bus_cmd_wen;
  logic [ADDRSIZE-1:0]  bus_cmd_addr;
  logic [WORDSIZE-1:0]  bus_cmd_wdata;
  logic                 bus_rsp_vld;
  logic [WORDSIZE-1:0]  bus_rsp_data;

  modport master (
    input  mem_req_vld,
    input  mem_req_wen,
    input  mem_addr,
    input  mem_wr_data,
    output mem_rd_data,
    output mem_req_done,
    output bus_cmd_vld,
    input  bus_cmd_rdy,
    output bus_cmd_wen,
    output bus_cmd_addr,
    output bus_cmd_wdata,
    input  bus_rsp_vld,
    input  bus_rsp_data
  );

  modport slave (
    output mem_req_vld,
    output mem_req_wen,
    output mem_addr,
    output mem_wr_data,
    input  mem_rd_data,
    input  mem_req_done,
    input  bus_cmd_vld,
    output bus_cmd_rdy,
    input  bus_cmd_wen,
    input  bus_cmd_addr,
    input  bus_cmd_wdata,
    output bus_rsp_vld,
    output bus_rsp_data
  );

endinterface

// File: rtl/cache_mem_burst_bridge.sv
// Memory-side stage of the write-back cache: turns one block request into a
// sequence of single-word bus transactions, ascending word order, one
// outstanding at a time. Fills are assembled into mem_rd_data slice by slice.
// Every output is a flop, so there is no input-to-output combinational path.
module cache_mem_burst_bridge #(
  parameter int unsigned ADDRSIZE  = 32,
  parameter int unsigned BLOCKSIZE = 128,
  parameter int unsigned WORDSIZE  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  cache_mem_burst_bridge_if.master  bif
);

  localparam int unsigned BEATS       = BLOCKSIZE / WORDSIZE;
  localparam int unsigned CNT_W       = $clog2(BEATS);
  localparam int unsigned WORD_SHIFT  = $clog2(WORDSIZE / 8);
  localparam int unsigned BLOCK_BYTES = BLOCKSIZE / 8;

  localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDRSIZE-1:0] OFF_MASK  = ADDRSIZE'(BLOCK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    RD_CMD,
    RD_WAIT,
    DONE
  } state_t;

  typedef logic [BEATS-1:0][WORDSIZE-1:0] block_t;

  state_t              state_q,       state_nxt;
  logic [CNT_W-1:0]    cnt_q,         cnt_nxt;
  logic [ADDRSIZE-1:0] base_q,        base_nxt;
  block_t              block_q,       block_nxt;
  block_t              rd_data_q,     rd_data_nxt;
  logic                cmd_vld_q,     cmd_vld_nxt;
  logic                cmd_wen_q,     cmd_wen_nxt;
  logic [ADDRSIZE-1:0] cmd_addr_q,    cmd_addr_nxt;
  logic [WORDSIZE-1:0] cmd_wdata_q,   cmd_wdata_nxt;
  logic                done_q,        done_nxt;

  // Word address of beat k within the block; base is block-aligned so no carry.
  function automatic logic [ADDRSIZE-1:0] beat_addr(input logic [ADDRSIZE-1:0] base,
                                                    input logic [CNT_W-1:0]    k);
    return base + (ADDRSIZE'(k) << WORD_SHIFT);
  endfunction

  // Next-state and next-output decode; bus command fields are precomputed for
  // the beat about to be presented so they can be registered.
  always_comb begin
    state_nxt     = state_q;
    cnt_nxt       = cnt_q;
    base_nxt      = base_q;
    block_nxt     = block_q;
    rd_data_nxt   = rd_data_q;
    cmd_vld_nxt   = 1'b0;
    cmd_wen_nxt   = 1'b0;
    cmd_addr_nxt  = cmd_addr_q;
    cmd_wdata_nxt = cmd_wdata_q;
    done_nxt      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bif.mem_req_vld) begin
          base_nxt      = bif.mem_addr & ~OFF_MASK;
          block_nxt     = bif.mem_wr_data;
          cnt_nxt       = '0;
          cmd_vld_nxt   = 1'b1;
          cmd_wen_nxt   = bif.mem_req_wen;
          cmd_addr_nxt  = base_nxt;
          cmd_wdata_nxt = bif.mem_wr_data[WORDSIZE-1:0];
          state_nxt     = bif.mem_req_wen ? WR_BEAT : RD_CMD;
        end
      end

      WR_BEAT: begin
        cmd_vld_nxt = 1'b1;
        cmd_wen_nxt = 1'b1;
        if (bif.bus_cmd_rdy) begin
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            cmd_vld_nxt = 1'b0;
            cmd_wen_nxt = 1'b0;
            done_nxt    = 1'b1;
            state_nxt   = DONE;
          end else begin
            cmd_addr_nxt  = beat_addr(base_q, cnt_nxt);
            cmd_wdata_nxt = block_q[cnt_nxt];
          end
        end
      end

      RD_CMD: begin
        cmd_vld_nxt = 1'b1;
        if (bif.bus_cmd_rdy) begin
          cmd_vld_nxt = 1'b0;
          state_nxt   = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bif.bus_rsp_vld) begin
          rd_data_nxt[cnt_q] = bif.bus_rsp_data;
          cnt_nxt            = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            cmd_vld_nxt  = 1'b1;
            cmd_addr_nxt = beat_addr(base_q, cnt_nxt);
            state_nxt    = RD_CMD;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      block_q     <= '0;
      rd_data_q   <= '0;
      cmd_vld_q   <= 1'b0;
      cmd_wen_q   <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      base_q      <= base_nxt;
      block_q     <= block_nxt;
      rd_data_q   <= rd_data_nxt;
      cmd_vld_q   <= cmd_vld_nxt;
      cmd_wen_q   <= cmd_wen_nxt;
      cmd_addr_q  <= cmd_addr_nxt;
      cmd_wdata_q <= cmd_wdata_nxt;
      done_q      <= done_nxt;
    end
  end

  assign bif.mem_rd_data   = rd_data_q;
  assign bif.mem_req_done  = done_q;
  assign bif.bus_cmd_vld   = cmd_vld_q;
  assign bif.bus_cmd_wen   = cmd_wen_q;
  assign bif.bus_cmd_addr  = cmd_addr_q;
  assign bif.bus_cmd_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_cache_mem_burst_bridge.sv
// Bench for cache_mem_burst_bridge: directed timing scenarios followed by a
// randomized run. Expected bus beats and completions are queued at issue time
// and consumed by an independent monitor.
module tb_cache_mem_burst_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 128;
  localparam int unsigned WW = 32;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          t0;
  } cmd_t;

  typedef struct {
    logic [127:0] rd;
    int           lat;
    int           t0;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_mem_burst_bridge_if #(.ADDRSIZE(AW), .BLOCKSIZE(BW), .WORDSIZE(WW)) bif ();

  cache_mem_burst_bridge #(.ADDRSIZE(AW), .BLOCKSIZE(BW), .WORDSIZE(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  cmd_t        exp_cmd[$];
  done_t       exp_done[$];
  logic [31:0] rd_words[$];
  logic [127:0] model_rd = '0;

  int rdy_mode = 0;   // 0 always ready, 1 random, 2 scripted stall
  int stall_t0 = 0;
  int rsp_dly  = 1;   // 0 means random 1..3
  int rsp_cnt  = 0;
  bit spur_en  = 1'b0;
  int rd_acc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_vld"},   128'(bif.bus_cmd_vld),   128'(0));
    chk({tag, "_cmd_wen"},   128'(bif.bus_cmd_wen),   128'(0));
    chk({tag, "_cmd_addr"},  128'(bif.bus_cmd_addr),  128'(0));
    chk({tag, "_cmd_wdata"}, 128'(bif.bus_cmd_wdata), 128'(0));
    chk({tag, "_rd_data"},   bif.mem_rd_data,         128'(0));
    chk({tag, "_done"},      128'(bif.mem_req_done),  128'(0));
  endtask

  // Memory side: ready generation and read responses.
  initial begin
    bif.bus_cmd_rdy  = 1'b0;
    bif.bus_rsp_vld  = 1'b0;
    bif.bus_rsp_data = '0;
    forever begin
      int idx;
      @(posedge clk);
      #1;
      idx = cyc - stall_t0 + 1;
      case (rdy_mode)
        1:       bif.bus_cmd_rdy = ($urandom % 4) != 0;
        2:       bif.bus_cmd_rdy = !(idx >= 3 && idx <= 5);
        default: bif.bus_cmd_rdy = 1'b1;
      endcase
      bif.bus_rsp_vld = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bif.bus_rsp_vld  = 1'b1;
          bif.bus_rsp_data = '0;
          if (rd_words.size() > 0) bif.bus_rsp_data = rd_words.pop_front();
        end
      end else if (spur_en && ($urandom % 3) == 0) begin
        bif.bus_rsp_vld  = 1'b1;
        bif.bus_rsp_data = $urandom;
      end
    end
  end

  // Monitor: compare presented beats and completions against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bif.bus_cmd_vld) begin
          if (exp_cmd.size() == 0) begin
            chk("extra_cmd", 128'(bif.bus_cmd_addr), 128'(0));
            if (bif.bus_cmd_addr == '0) chk("extra_cmd_vld", 128'(bif.bus_cmd_vld), 128'(0));
          end else begin
            cmd_t e;
            e = exp_cmd[0];
            chk("cmd_addr", 128'(bif.bus_cmd_addr), 128'(e.addr));
            chk("cmd_wen",  128'(bif.bus_cmd_wen),  128'(e.wen));
            if (e.wen) chk("cmd_wdata", 128'(bif.bus_cmd_wdata), 128'(e.wdata));
            if (bif.bus_cmd_rdy) begin
              void'(exp_cmd.pop_front());
              if (e.lat != 0) chk("cmd_cycle", 128'(cyc - e.t0 + 1), 128'(e.lat));
              if (!e.wen) begin
                rsp_cnt = (rsp_dly > 0) ? rsp_dly : int'($urandom_range(3, 1));
                rd_acc++;
              end
            end
          end
        end
        if (bif.mem_req_done) begin
          if (exp_done.size() == 0) begin
            chk("extra_done", 128'(bif.mem_req_done), 128'(0));
          end else begin
            done_t d;
            d = exp_done.pop_front();
            chk("rd_data", bif.mem_rd_data, d.rd);
            if (d.lat != 0) chk("done_cycle", 128'(cyc - d.t0 + 1), 128'(d.lat));
            if (exp_cmd.size() != 0) chk("beats_left_at_done", 128'(exp_cmd.size()), 128'(0));
          end
        end
      end
    end
  end

  // Issue one block request; mode 1 = nominal timing, 2 = stall on beat 2.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [127:0] blk,
                       input int mode, output int t0);
    logic [31:0]      base;
    logic [3:0][31:0] words;
    cmd_t             c;
    done_t            d;
    base  = {addr[31:4], 4'h0};
    words = blk;
    @(posedge clk);
    #1;
    t0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      c.wen   = wen;
      c.addr  = base + 32'(4 * k);
      c.wdata = words[2'(k)];
      c.t0    = t0;
      case (mode)
        1:       c.lat = wen ? k + 1 : 2 * k + 1;
        2:       c.lat = (k < 2) ? k + 1 : k + 4;
        default: c.lat = 0;
      endcase
      exp_cmd.push_back(c);
      if (!wen) rd_words.push_back(words[2'(k)]);
    end
    if (!wen) model_rd = blk;
    d.rd  = model_rd;
    d.t0  = t0;
    d.lat = (mode == 1) ? (wen ? 5 : 9) : (mode == 2) ? 8 : 0;
    exp_done.push_back(d);
    bif.mem_req_vld = 1'b1;
    bif.mem_req_wen = wen;
    bif.mem_addr    = addr;
    bif.mem_wr_data = wen ? blk : ~blk;
    @(posedge clk);
    #1;
    bif.mem_req_vld = 1'b0;
  endtask

  // One-cycle strobe with junk contents that the bridge must ignore.
  task automatic junk_strobe();
    bif.mem_req_vld = 1'b1;
    bif.mem_req_wen = 1'($urandom);
    bif.mem_addr    = $urandom;
    bif.mem_wr_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
    bif.mem_req_vld = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bif.mem_req_done) got = 1'b1;
    end
    if (!got) chk("done_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    int t0;
    int acc0;
    bit seen;
    bif.mem_req_vld = 1'b0;
    bif.mem_req_wen = 1'b0;
    bif.mem_addr    = '0;
    bif.mem_wr_data = '0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 rst = 1'b1;

    // fill with nominal timing
    rdy_mode = 0; rsp_dly = 1;
    issue(1'b0, 32'h0000_1234, {32'h44, 32'h33, 32'h22, 32'h11}, 1, t0);
    wait_done();

    // write-back, strobe during DONE must be dropped
    issue(1'b1, 32'h8000_00F0, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, 1, t0);
    repeat (4) @(posedge clk);
    #1;
    junk_strobe();
    repeat (4) @(posedge clk);
    chk("idle_after_drop", 128'(exp_cmd.size() + exp_done.size()), 128'(0));

    // write-back then fill back to back, spurious responses in the mix
    spur_en = 1'b1;
    issue(1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1, t0);
    wait_done();
    issue(1'b0, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1, t0);
    wait_done();
    spur_en = 1'b0;

    // strobe during write beats is ignored
    issue(1'b1, 32'h0000_4A5C, {$urandom, $urandom, $urandom, $urandom}, 1, t0);
    @(posedge clk);
    #1;
    junk_strobe();
    wait_done();

    // backpressure on beat 2
    issue(1'b1, 32'h1234_5670, {$urandom, $urandom, $urandom, $urandom}, 2, t0);
    stall_t0 = t0;
    rdy_mode = 2;
    wait_done();
    rdy_mode = 0;

    // reset while waiting for the beat-1 read response
    rsp_dly = 2;
    acc0 = rd_acc;
    issue(1'b0, 32'hCAFE_0010, {32'h0BAD_0004, 32'h0BAD_0003, 32'h0BAD_0002, 32'h0BAD_0001}, 0, t0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #3;
      if (rd_acc >= acc0 + 2) seen = 1'b1;
    end
    if (!seen) chk("rd_beat1_timeout", 128'(0), 128'(1));
    rst = 1'b0;
    rsp_cnt = 0;
    rd_words.delete();
    exp_cmd.delete();
    exp_done.delete();
    model_rd = '0;
    #1;
    check_all_zero("midfill_rst");
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", 128'(bif.mem_req_done), 128'(0));
    rsp_dly = 1;
    issue(1'b0, 32'h0000_7770, {$urandom, $urandom, $urandom, $urandom}, 1, t0);
    wait_done();

    // randomized traffic
    rdy_mode = 1; rsp_dly = 0; spur_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom), $urandom, {$urandom, $urandom, $urandom, $urandom}, 0, t0);
      if ($urandom % 2) begin
        repeat ($urandom_range(2, 0)) @(posedge clk);
        #1;
        junk_strobe();
      end
      wait_done();
      repeat ($urandom_range(2, 0)) @(posedge clk);
    end
    spur_en = 1'b0;
    repeat (5) @(posedge clk);
    chk("leftover_beats", 128'(exp_cmd.size()), 128'(0));
    chk("leftover_done",  128'(exp_done.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
